// File: rtl/hdmi_rx_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hdmi_rx_capture: validates DE/VS stream timing, crops and decimates the
// Game Boy window into framebuffer write strobes.            Rev 1.0
// ---------------------------------------------------------------------------
module hdmi_rx_capture #(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 144,
  parameter int XDIV        = 3,
  parameter int YDIV        = 3,
  parameter int XSTART      = 80,
  parameter int YSTART      = 24,
  parameter int HSIZE       = 640,
  parameter int VSIZE       = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clock25,
  input  logic        resetn,
  input  logic [23:0] vid_d,
  input  logic        vid_de,
  input  logic        vid_vs,
  output logic        wr_en,
  output logic [11:0] wr_x,
  output logic [11:0] wr_y,
  output logic [23:0] wr_rgb,
  output logic        frame_done,
  output logic        locked,
  output logic        err
);

  localparam logic [11:0] X_LO   = 12'(XSTART);
  localparam logic [11:0] X_HI   = 12'(XSTART + XDIV * WIDTH);
  localparam logic [11:0] Y_LO   = 12'(YSTART);
  localparam logic [11:0] Y_HI   = 12'(YSTART + YDIV * HEIGHT);
  localparam logic [11:0] H_LEN  = 12'(HSIZE);
  localparam logic [11:0] V_LEN  = 12'(VSIZE);
  localparam logic [11:0] X_LAST = 12'(WIDTH - 1);
  localparam logic [11:0] Y_LAST = 12'(HEIGHT - 1);
  localparam logic [11:0] SAT    = 12'hFFF;
  localparam logic [7:0]  XPH_LAST = 8'(XDIV - 1);
  localparam logic [7:0]  YPH_LAST = 8'(YDIV - 1);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

  logic [23:0] s_d;
  logic        s_de, s_vs, p_de, p_vs;
  logic [11:0] col, ln, xc, yc;
  logic [7:0]  xph, yph;
  logic        seen_vs, bad_flag, armed;
  logic [3:0]  lock_cnt;

  logic        de_fall, vs_rise, line_bad, vs_de_bad, frame_bad, frame_good, err_c;
  logic [11:0] ln_inc, ln_end;
  logic [3:0]  lock_cnt_n;
  logic        locked_n, in_x, in_y, in_win, fire, wr_c;

  always_comb begin
    de_fall   = p_de & ~s_de;
    vs_rise   = s_vs & ~p_vs;
    line_bad  = de_fall & (col != H_LEN);
    vs_de_bad = vs_rise & s_de;
    ln_inc    = (ln == SAT) ? ln : ln + 12'd1;
    ln_end    = de_fall ? ln_inc : ln;
    // A line ending on the VS-rise cycle still belongs to the frame being judged.
    frame_bad  = vs_rise & seen_vs & (bad_flag | line_bad | vs_de_bad | (ln_end != V_LEN));
    frame_good = vs_rise & seen_vs & ~frame_bad;
    err_c      = line_bad | vs_de_bad | frame_bad;

    lock_cnt_n = lock_cnt;
    if (err_c)
      lock_cnt_n = 4'd0;
    else if (frame_good && lock_cnt != LOCK_N)
      lock_cnt_n = lock_cnt + 4'd1;
    locked_n = (lock_cnt_n == LOCK_N);

    in_x   = (col >= X_LO) && (col < X_HI);
    in_y   = (ln >= Y_LO) && (ln < Y_HI);
    in_win = s_de & in_x & in_y;
    fire   = in_win & (xph == 8'd0) & (yph == 8'd0);
    wr_c   = fire & armed & ~err_c;
  end

  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      s_d        <= 24'd0;
      s_de       <= 1'b0;
      s_vs       <= 1'b0;
      p_de       <= 1'b0;
      p_vs       <= 1'b0;
      col        <= 12'd0;
      ln         <= 12'd0;
      xc         <= 12'd0;
      yc         <= 12'd0;
      xph        <= 8'd0;
      yph        <= 8'd0;
      seen_vs    <= 1'b0;
      bad_flag   <= 1'b0;
      armed      <= 1'b0;
      lock_cnt   <= 4'd0;
      wr_en      <= 1'b0;
      wr_x       <= 12'd0;
      wr_y       <= 12'd0;
      wr_rgb     <= 24'd0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      s_d  <= vid_d;
      s_de <= vid_de;
      s_vs <= vid_vs;
      p_de <= s_de;
      p_vs <= s_vs;

      if (de_fall)
        col <= 12'd0;
      else if (s_de && col != SAT)
        col <= col + 12'd1;

      if (vs_rise)
        ln <= 12'd0;
      else if (de_fall)
        ln <= ln_inc;

      if (vs_rise)
        bad_flag <= 1'b0;
      else if (line_bad)
        bad_flag <= 1'b1;

      if (vs_rise)
        seen_vs <= 1'b1;

      lock_cnt <= lock_cnt_n;
      locked   <= locked_n;
      err      <= err_c;

      if (err_c)
        armed <= 1'b0;
      else if (vs_rise)
        armed <= locked_n;

      // xc/yc are the coordinates the next block top-left pixel will be written at.
      if (vs_rise) begin
        xph <= 8'd0;
        yph <= 8'd0;
        xc  <= 12'd0;
        yc  <= 12'd0;
      end else if (de_fall) begin
        xph <= 8'd0;
        xc  <= 12'd0;
        if (in_y) begin
          if (yph == YPH_LAST) begin
            yph <= 8'd0;
            yc  <= yc + 12'd1;
          end else begin
            yph <= yph + 8'd1;
          end
        end
      end else if (in_win) begin
        xph <= (xph == XPH_LAST) ? 8'd0 : xph + 8'd1;
        if (fire)
          xc <= xc + 12'd1;
      end

      wr_en      <= wr_c;
      frame_done <= wr_c & (xc == X_LAST) & (yc == Y_LAST);
      if (wr_c) begin
        wr_x   <= xc;
        wr_y   <= yc;
        wr_rgb <= s_d;
      end
    end
  end

endmodule
`default_nettype wire
